// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arb_pkg : shared state and owner encodings for the memory arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// mem_arbiter_if : requester, memory and debug signals of the memory arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic          i_wen;
    logic [AW-1:0] i_address;
    logic [DW-1:0] i_datain;
    logic [3:0]    i_byte_select;
    logic          i_ready;
    logic          i_err;
    logic [DW-1:0] i_dataout;

    logic          d_req;
    logic          d_wen;
    logic [AW-1:0] d_address;
    logic [DW-1:0] d_datain;
    logic [3:0]    d_byte_select;
    logic          d_ready;
    logic          d_err;
    logic [DW-1:0] d_dataout;

    logic          mem_ren;
    logic          mem_wen;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_datain;
    logic [3:0]    mem_byte_select;
    logic [DW-1:0] mem_dataout;
    logic          mem_ready;

    logic [1:0]    owner;

    // Arbiter view
    modport master (
        input  i_req, i_wen, i_address, i_datain, i_byte_select,
        output i_ready, i_err, i_dataout,
        input  d_req, d_wen, d_address, d_datain, d_byte_select,
        output d_ready, d_err, d_dataout,
        output mem_ren, mem_wen, mem_address, mem_datain, mem_byte_select,
        input  mem_dataout, mem_ready,
        output owner
    );

    // Requester / memory view
    modport slave (
        output i_req, i_wen, i_address, i_datain, i_byte_select,
        input  i_ready, i_err, i_dataout,
        output d_req, d_wen, d_address, d_datain, d_byte_select,
        input  d_ready, d_err, d_dataout,
        input  mem_ren, mem_wen, mem_address, mem_datain, mem_byte_select,
        output mem_dataout, mem_ready,
        input  owner
    );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
// ============================================================================
// rr_pick2 : two-way round-robin selector; a tie goes to the side not last served
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick2 (
    input  wire logic req_i,
    input  wire logic req_d,
    input  wire logic last_served,   // 0 = I, 1 = D
    output logic      gnt_i,
    output logic      gnt_d
);

    assign gnt_i = req_i && (!req_d || last_served);
    assign gnt_d = req_d && (!req_i || !last_served);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : round-robin sharing of the main-memory port between I and D
//               refill paths, with a per-transaction watchdog
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  wire logic     clk,
    input  wire logic     reset,
    mem_arbiter_if.master bus
);

    localparam int                   c_cnt_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_owner;
    logic                 r_last_served;
    logic                 r_wen;
    logic                 r_timeout;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [AW-1:0]        r_address;
    logic [DW-1:0]        r_datain;
    logic [3:0]           r_byte_select;
    logic [DW-1:0]        r_i_dataout;
    logic [DW-1:0]        r_d_dataout;

    logic                 w_gnt_i;
    logic                 w_gnt_d;
    logic                 w_grant;
    logic                 w_done_ok;
    logic                 w_done_to;

    rr_pick2 u_pick (
        .req_i       (bus.i_req),
        .req_d       (bus.d_req),
        .last_served (r_last_served),
        .gnt_i       (w_gnt_i),
        .gnt_d       (w_gnt_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // mem_ready takes priority over the watchdog on the final BUSY cycle
    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_done_ok = 1'b0;
        w_done_to = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_i || w_gnt_d) begin
                    w_grant = 1'b1;
                    w_next  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.mem_ready) begin
                    w_done_ok = 1'b1;
                    w_next    = ST_DONE;
                end else if (r_cnt == c_cnt_last) begin
                    w_done_to = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner       <= OWN_NONE;
            r_last_served <= 1'b1;
            r_wen         <= 1'b0;
            r_timeout     <= 1'b0;
            r_cnt         <= '0;
            r_address     <= '0;
            r_datain      <= '0;
            r_byte_select <= '0;
            r_i_dataout   <= '0;
            r_d_dataout   <= '0;
        end else begin
            if (w_grant) begin
                r_owner       <= w_gnt_i ? OWN_I : OWN_D;
                r_wen         <= w_gnt_i ? bus.i_wen : bus.d_wen;
                r_address     <= w_gnt_i ? bus.i_address : bus.d_address;
                r_datain      <= w_gnt_i ? bus.i_datain : bus.d_datain;
                r_byte_select <= w_gnt_i ? bus.i_byte_select : bus.d_byte_select;
                r_cnt         <= '0;
                r_timeout     <= 1'b0;
            end else if (w_done_ok || w_done_to) begin
                r_last_served <= (r_owner == OWN_D);
                r_timeout     <= w_done_to;
                if (w_done_ok && !r_wen) begin
                    if (r_owner == OWN_I) begin
                        r_i_dataout <= bus.mem_dataout;
                    end else begin
                        r_d_dataout <= bus.mem_dataout;
                    end
                end
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (r_state == ST_DONE) begin
                r_owner <= OWN_NONE;
            end
        end
    end

    assign bus.mem_ren         = (r_state == ST_BUSY) && !r_wen;
    assign bus.mem_wen         = (r_state == ST_BUSY) && r_wen;
    assign bus.mem_address     = r_address;
    assign bus.mem_datain      = r_datain;
    assign bus.mem_byte_select = r_byte_select;
    assign bus.owner           = r_owner;

    assign bus.i_ready   = (r_state == ST_DONE) && (r_owner == OWN_I);
    assign bus.i_err     = (r_state == ST_DONE) && (r_owner == OWN_I) && r_timeout;
    assign bus.i_dataout = r_i_dataout;
    assign bus.d_ready   = (r_state == ST_DONE) && (r_owner == OWN_D);
    assign bus.d_err     = (r_state == ST_DONE) && (r_owner == OWN_D) && r_timeout;
    assign bus.d_dataout = r_d_dataout;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single backing main-memory port between the instruction-side MMU refill path and the data-side MMU refill/writeback path.
- Each side raises a held request on a cache miss or writeback; the arbiter grants one side at a time, round-robin.
- It drives the memory strobes and waits for the memory's completion signal, then returns a one-cycle registered ready with read data.
- A watchdog aborts any transaction the memory fails to complete within a bounded number of cycles.

Parameters:
- AW, 32: address width (byte address, passed through unshifted).
- DW, 32: data width.
- TIMEOUT, 64: maximum cycles in BUSY before abort; must be ≥2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  instruction-side request; held until i_ready.
- i_wen  in  1  1 = write, 0 = read.
- i_address  in  AW  instruction-side address.
- i_datain  in  DW  instruction-side write data.
- i_byte_select  in  4  instruction-side byte lanes.
- i_ready  out  1  one-cycle completion pulse.
- i_err  out  1  valid with i_ready; 1 = timed out.
- i_dataout  out  DW  read data, valid while i_ready = 1 and held afterwards.
- d_req, d_wen, d_address, d_datain, d_byte_select, d_ready, d_err, d_dataout: same as the i_ ports, for the data side.
- mem_ren  out  1  memory read strobe.
- mem_wen  out  1  memory write strobe.
- mem_address  out  AW  latched address.
- mem_datain  out  DW  latched write data.
- mem_byte_select  out  4  latched byte lanes.
- mem_dataout  in  DW  memory read data.
- mem_ready  in  1  memory completion signal (memsig).
- owner  out  2  00 = none, 01 = I, 10 = D (debug).

Behaviour:
- States: IDLE, BUSY, DONE. Registers: owner, last_served (1 bit, 0 = I, 1 = D), cnt (clog2(TIMEOUT+1) bits).
- Reset (synchronous, wins over everything; mid-transaction aborts with no ready pulse):
  - state = IDLE, owner = 00, last_served = D, cnt = 0.
  - All strobes, ready and err = 0; dataouts = 0; mem_address, mem_datain and mem_byte_select = 0.
- IDLE:
  - No request: stay in IDLE, strobes 0.
  - One request: grant that side.
  - Both requests: grant the side that is not last_served. After reset, I wins the first tie.
  - On grant: latch that side's address, datain, byte_select and wen into the mem_* registers; set owner; cnt = 0; go to BUSY.
- BUSY:
  - mem_ren = !latched_wen; mem_wen = latched_wen. Both are held stable for every BUSY cycle.
  - Requester inputs are ignored; the latched copies are used.
  - On mem_ready = 1 at a posedge:
    - If the transaction is a read, capture mem_dataout into the owner's dataout register.
    - Set last_served = owner; go to DONE.
    - Strobes drop at that same edge.
  - Otherwise cnt increments. When cnt == TIMEOUT-1 and mem_ready = 0:
    - go to DONE with err pending; dataout is unchanged; last_served = owner.
  - mem_ready arriving on the timeout cycle counts as success (mem_ready wins).
- DONE (exactly one cycle):
  - Owner's x_ready = 1; x_err = timeout flag; strobes 0.
  - Requests are not sampled; go to IDLE and set owner = 00.
  - Requesters deassert req in the cycle after they see x_ready.
- Latency:
  - req first high at edge N → strobes asserted from cycle N+1.
  - mem_ready sampled at edge M → x_ready high during cycle M+1.
  - Minimum request-to-ready time is 3 edges (mem_ready in the first BUSY cycle).
- Back-to-back: the earliest re-grant is the IDLE cycle after DONE. A side that holds req continuously alternates with the other side when both request.
- mem_ready while in IDLE or DONE is ignored.
- i_ready and d_ready are never high in the same cycle.

Decomposition:
- Shared package (mem_arb_pkg) holds:
  - state encoding constants ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2;
  - owner codes OWN_NONE, OWN_I, OWN_D.
- One sub-module, rr_pick2: combinational round-robin selector. Inputs req_i, req_d, last_served; outputs gnt_i, gnt_d.
- Everything else lives in the top-level FSM.

Test Plan:
- Single I read: i_req = 1 at edge 0, i_address = 0x100, mem_ready at edge 3 with mem_dataout = 0xDEADBEEF → mem_ren high in cycles 1–3, i_ready = 1 in cycle 4, i_dataout = 0xDEADBEEF, i_err = 0.
- Simultaneous after reset: i_req = d_req = 1, memory completes after 2 cycles → I served first, then D granted in the IDLE cycle after I's DONE. With both reqs held high, grants alternate I, D, I, D.
- D write: d_wen = 1, d_address = 0x2004, d_datain = 0x12345678, byte_select = 4'b0011 → mem_wen high and mem_ren low; mem_* values equal the latched values even if d_address changes mid-BUSY; d_ready pulses once and d_dataout is unchanged.
- Timeout: TIMEOUT = 4, mem_ready never asserted → strobes high exactly 4 cycles, then x_ready = 1 with x_err = 1, FSM back in IDLE. Also check mem_ready arriving on the 4th cycle → err = 0.
- Reset mid-BUSY: assert reset during cycle 2 of an I read → at the next edge all outputs are at reset values, no i_ready pulse, and the next tie goes to I.
- Spurious mem_ready in IDLE with no requests → no ready pulse, owner stays 00.
